// File: rtl/sens_pack_pkg.sv
// Shared types and constants for the sensor trace packer.
// SENS_POPCOUNT_EN selects Hamming-weight packing; without it words pass through one per ack.
package sens_pack_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } sens_state_e;

  localparam int LANE_W = 8;
  localparam int LANES  = 16;

  // Timeout counter must be able to hold the value TIMEOUT itself.
  function automatic int tmr_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/popcount128.sv
// Two-stage Hamming weight of a 128-bit word: per-byte counts, then an adder tree.
// Only instantiated when SENS_POPCOUNT_EN is defined.
module popcount128
  import sens_pack_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_vld,
  input  logic [127:0]      din,
  output logic              out_vld,
  output logic [LANE_W-1:0] weight
);

  logic [3:0]        grp_d [LANES];
  logic [3:0]        grp_q [LANES];
  logic              vld_q;
  logic [LANE_W-1:0] sum;

  always_comb begin
    for (int g = 0; g < LANES; g++) begin
      grp_d[g] = 4'd0;
      for (int b = 0; b < 8; b++) begin
        grp_d[g] = grp_d[g] + {3'd0, din[g*8+b]};
      end
    end
  end

  always_comb begin
    sum = '0;
    for (int g = 0; g < LANES; g++) begin
      sum = sum + {4'd0, grp_q[g]};
    end
  end

  // The valid bit follows the data through both stages; clr kills anything in flight.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= 1'b0;
      out_vld <= 1'b0;
      weight  <= '0;
      for (int g = 0; g < LANES; g++) grp_q[g] <= 4'd0;
    end else begin
      vld_q   <= in_vld && !clr;
      out_vld <= vld_q && !clr;
      if (in_vld) begin
        for (int g = 0; g < LANES; g++) grp_q[g] <= grp_d[g];
      end
      if (vld_q) weight <= sum;
    end
  end

endmodule

// File: rtl/sens_trace_packer.sv
// Drains N_SAMPLES sensor FIFO words per run and hands them on through a held valid/ack port.
// SENS_POPCOUNT_EN: pack 16 Hamming weights per output word; otherwise one raw word per ack.
module sens_trace_packer
  import sens_pack_pkg::*;
#(
  parameter int N_SAMPLES    = 128,
  parameter int SENSOR_WIDTH = 128,
  parameter int TIMEOUT      = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_n,
  input  logic                    start_i,
  output logic                    fifo_drdy_o,
  input  logic [SENSOR_WIDTH-1:0] fifo_dout_i,
  input  logic                    fifo_dvld_i,
  output logic [SENSOR_WIDTH-1:0] pack_dout_o,
  output logic                    pack_dvld_o,
  input  logic                    pack_ack_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output sens_state_e             dbg_state
);

  // Handshakes: fifo_drdy_o is a one-cycle request answered by a one-cycle fifo_dvld_i,
  // with one request outstanding; pack_dvld_o holds until pack_ack_i is seen while it is high.
  localparam int TMR_W = tmr_width(TIMEOUT);
  localparam int CNT_W = $clog2(N_SAMPLES + 1);

  sens_state_e             state_q, state_d;
  logic [TMR_W-1:0]        tmr_q;
  logic [CNT_W-1:0]        smp_q;
  logic                    err_q, done_q, dvld_q;
  logic [SENSOR_WIDTH-1:0] data_q;
  logic                    run_start, take, abort, acked, run_end, group_last;

  assign run_start = (state_q == IDLE) && start_i;
  assign take      = (state_q == WAIT) && fifo_dvld_i;
  assign abort     = (state_q == WAIT) && !fifo_dvld_i && (tmr_q == TMR_W'(TIMEOUT - 1));
  assign acked     = (state_q == HOLD) && dvld_q && pack_ack_i;
  assign run_end   = (smp_q == CNT_W'(N_SAMPLES));

`ifdef SENS_POPCOUNT_EN
  logic [3:0]        iss_q, wr_q;
  logic              pc_vld;
  logic [LANE_W-1:0] pc_weight;

  assign group_last = (iss_q == 4'(LANES - 1));

  popcount128 u_popcount (
    .clk_i   (clk_i),
    .rst_n   (rst_n),
    .clr     (run_start || abort),
    .in_vld  (take),
    .din     (fifo_dout_i),
    .out_vld (pc_vld),
    .weight  (pc_weight)
  );
`else
  assign group_last = 1'b1;
`endif

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_i) state_d = REQ;
      REQ:  state_d = WAIT;
      WAIT: begin
        if (take)       state_d = group_last ? HOLD : REQ;
        else if (abort) state_d = IDLE;
      end
      HOLD: if (acked) state_d = run_end ? IDLE : REQ;
      default: state_d = IDLE;
    endcase
  end

  // tmr_q equals the number of cycles elapsed since the request cycle.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      tmr_q  <= '0;
      smp_q  <= '0;
      err_q  <= 1'b0;
      done_q <= 1'b0;
      dvld_q <= 1'b0;
      data_q <= '0;
`ifdef SENS_POPCOUNT_EN
      iss_q  <= 4'd0;
      wr_q   <= 4'd0;
`endif
    end else begin
      done_q <= 1'b0;
      if (run_start) begin
        smp_q  <= '0;
        err_q  <= 1'b0;
        dvld_q <= 1'b0;
        data_q <= '0;
`ifdef SENS_POPCOUNT_EN
        iss_q  <= 4'd0;
        wr_q   <= 4'd0;
`endif
      end
      if (state_q == REQ)       tmr_q <= TMR_W'(1);
      else if (state_q == WAIT) tmr_q <= tmr_q + TMR_W'(1);
      if (take) begin
        smp_q <= smp_q + CNT_W'(1);
`ifdef SENS_POPCOUNT_EN
        iss_q <= group_last ? 4'd0 : iss_q + 4'd1;
`else
        data_q <= fifo_dout_i;
        dvld_q <= 1'b1;
`endif
      end
`ifdef SENS_POPCOUNT_EN
      if (pc_vld) begin
        data_q[wr_q*LANE_W +: LANE_W] <= pc_weight;
        wr_q <= wr_q + 4'd1;
        if (wr_q == 4'(LANES - 1)) dvld_q <= 1'b1;
      end
`endif
      if (abort) begin
        err_q  <= 1'b1;
        dvld_q <= 1'b0;
        data_q <= '0;
`ifdef SENS_POPCOUNT_EN
        iss_q  <= 4'd0;
        wr_q   <= 4'd0;
`endif
      end
      if (acked) begin
        dvld_q <= 1'b0;
        data_q <= '0;
        if (run_end) done_q <= 1'b1;
      end
    end
  end

  assign fifo_drdy_o = (state_q == REQ);
  assign pack_dout_o = data_q;
  assign pack_dvld_o = dvld_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_sens_trace_packer.sv
// Directed bench for sens_trace_packer; follows SENS_POPCOUNT_EN to pick packed or raw expectations.
module tb_sens_trace_packer;
  import sens_pack_pkg::*;

`ifdef SENS_POPCOUNT_EN
  localparam int G  = 16;
  localparam int NS = 32;
`else
  localparam int G  = 1;
  localparam int NS = 2;
`endif
  localparam int TMO = 255;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         dvld = 1'b0;
  logic         ack = 1'b0;
  logic [127:0] dout = '0;
  logic         drdy, pack_dvld, busy, done, err;
  logic [127:0] pack_dout;
  sens_state_e  st;

  int           cyc = 0;
  int           n_checks = 0;
  int           n_fail = 0;
  logic [127:0] exp_q[$];

  sens_trace_packer #(.N_SAMPLES(NS), .SENSOR_WIDTH(128), .TIMEOUT(TMO)) dut (
    .clk_i       (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .fifo_drdy_o (drdy),
    .fifo_dout_i (dout),
    .fifo_dvld_i (dvld),
    .pack_dout_o (pack_dout),
    .pack_dvld_o (pack_dvld),
    .pack_ack_i  (ack),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err),
    .dbg_state   (st)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // stimulus patterns and expected output model
  function automatic logic [127:0] word_of(input int pat, input int k);
    logic [127:0] w;
    case (pat)
      0:       w = '1;
      1:       w = (128'd1 << k) - 128'd1;
      default: w = {32'hC0DE_0000 | 32'(k), 32'h1234_5678, 32'(k), 32'hF0F0_0F0F};
    endcase
    return w;
  endfunction

  function automatic logic [127:0] exp_out(input int pat, input int grp);
    logic [127:0] e;
    e = '0;
`ifdef SENS_POPCOUNT_EN
    for (int j = 0; j < 16; j++) e[j*8 +: 8] = 8'($countones(word_of(pat, grp*16 + j)));
`else
    e = word_of(pat, grp);
`endif
    return e;
  endfunction

  // driver tasks
  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("drdy_after_start", drdy, 1'b1);
    check("err_cleared", err, 1'b0);
    check("busy_run", busy, 1'b1);
  endtask

  task automatic serve_word(input logic [127:0] w);
    for (int i = 0; i < 20 && !drdy; i++) tick();
    check("drdy_seen", drdy, 1'b1);
    tick();
    check("drdy_one_cycle", drdy, 1'b0);
    dvld = 1'b1;
    dout = w;
    tick();
    dvld = 1'b0;
    dout = '0;
  endtask

  task automatic collect(input string tag);
`ifdef SENS_POPCOUNT_EN
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("pk_dvld_early", pack_dvld, 1'b0);
    check("hold_wait_state", st, HOLD);
    tick();
`endif
    check("pk_dvld_rise", pack_dvld, 1'b1);
    check("sb_size", exp_q.size(), 1);
    if (exp_q.size() != 0) check(tag, pack_dout, exp_q.pop_front());
  endtask

  task automatic release_out(input logic last);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("pk_dvld_fall", pack_dvld, 1'b0);
    check("done_at_ack", done, last);
    if (last) begin
      check("busy_end", busy, 1'b0);
      tick();
      check("done_pulse", done, 1'b0);
    end else begin
      check("drdy_after_ack", drdy, 1'b1);
    end
  endtask

  task automatic hold_test(input int n);
    logic [127:0] snap;
    int drq, chg;
    snap = pack_dout;
    drq = 0;
    chg = 0;
    for (int i = 0; i < n; i++) begin
      if (i == 10) start = 1'b1;
      if (i == 20) begin
        dvld = 1'b1;
        dout = ~snap;
      end
      tick();
      start = 1'b0;
      dvld = 1'b0;
      dout = '0;
      if (drdy) drq++;
      if (pack_dout !== snap) chg++;
    end
    check("hold_no_drdy", drq, 0);
    check("hold_stable", chg, 0);
    check("hold_dvld", pack_dvld, 1'b1);
    check("hold_state", st, HOLD);
  endtask

  task automatic run(input int pat, input int hold_cycles);
    start_run();
    for (int g = 0; g < NS / G; g++) begin
      for (int j = 0; j < G; j++) begin
        serve_word(word_of(pat, g*G + j));
        if (j != G - 1) check("req_spacing", drdy, 1'b1);
      end
      exp_q.push_back(exp_out(pat, g));
      collect("pack_data");
      if (hold_cycles > 0 && g == 0) hold_test(hold_cycles);
      release_out(g == NS / G - 1);
    end
  endtask

  task automatic timeout_test();
    int c0, done_seen;
    start_run();
    c0 = cyc;
    done_seen = 0;
    for (int i = 0; i < 300 && !err; i++) begin
      ack = (i == 5);
      tick();
      ack = 1'b0;
      if (done) done_seen++;
    end
    check("tmo_cycles", cyc - c0, TMO);
    check("tmo_busy", busy, 1'b0);
    check("tmo_no_done", done_seen, 0);
    check("tmo_state", st, IDLE);
    tick();
    check("err_sticky", err, 1'b1);
  endtask

  task automatic reset_mid_run();
    start_run();
`ifdef SENS_POPCOUNT_EN
    for (int k = 0; k < 7; k++) serve_word(word_of(1, k));
`else
    serve_word(word_of(1, 0));
    exp_q.push_back(word_of(1, 0));
    collect("pre_reset_data");
    release_out(1'b0);
`endif
    tick();
    rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_state", st, IDLE);
    check("rst_pk_dvld", pack_dvld, 1'b0);
    check("rst_pk_dout", pack_dout, 128'd0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    repeat (3) tick();
    check("reset_drdy", drdy, 1'b0);
    check("reset_pk_dvld", pack_dvld, 1'b0);
    check("reset_pk_dout", pack_dout, 128'd0);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_err", err, 1'b0);
    check("reset_state", st, IDLE);
    rst_n = 1'b1;
    tick();
    // FIFO data valid while idle must not produce output
    dvld = 1'b1;
    dout = '1;
    tick();
    dvld = 1'b0;
    dout = '0;
    tick();
    check("idle_dvld_ignored", pack_dvld, 1'b0);

    run(0, 0);
    run(1, 50);
    timeout_test();
    reset_mid_run();
    run(2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sens_trace_packer.md
# sens_trace_packer

Downstream consumer of the sensor sample FIFO, in the `aes_clk` domain between `sensor_fifo` and the control FSM. On a start pulse it drains `N_SAMPLES` 128-bit sensor words using the FIFO's request/valid handshake. Each word is compressed to its 8-bit Hamming weight, and 16 weights are packed into one 128-bit output word. The FSM can then return 16 samples per readout instead of one.

## Interface
Parameters:
- `N_SAMPLES`, 128: words drained per run; must be a multiple of 16.
- `SENSOR_WIDTH`, 128: FIFO word width; fixed at 128.
- `TIMEOUT`, 255: maximum cycles from request to `fifo_dvld_i` before aborting.

Ports (one clock; reset is asynchronous and active-low):
- `clk_i`  in  1  `aes_clk`
- `rst_n`  in  1  asynchronous, active-low reset
- `start_i`  in  1  one-cycle pulse that begins a run
- `fifo_drdy_o`  out  1  one-cycle read request to the sensor FIFO
- `fifo_dout_i`  in  128  FIFO data, valid with `fifo_dvld_i`
- `fifo_dvld_i`  in  1  FIFO data valid, one cycle
- `pack_dout_o`  out  128  packed output word
- `pack_dvld_o`  out  1  output valid; held until acknowledged
- `pack_ack_i`  in  1  consumer accepts the output word
- `busy_o`  out  1  run in progress
- `done_o`  out  1  one-cycle pulse when a run completes normally
- `err_o`  out  1  sticky timeout flag; cleared by the next `start_i`

## Operation
- States: `IDLE`, `REQ`, `WAIT`, `HOLD`.
- `IDLE`: `start_i` clears the sample counter, lane counter and `err_o`, then enters `REQ`.
- `REQ`: pulse `fifo_drdy_o` for one cycle, start the timeout counter, enter `WAIT`.
- `WAIT`: on `fifo_dvld_i`, capture the word into the popcount pipeline and increment the issued counter.
  - If 16 requests have been issued since the last flush, enter `HOLD`; otherwise enter `REQ`.
  - If the timeout counter reaches `TIMEOUT`: set `err_o`, discard partial lanes, return to `IDLE` without `done_o`.
- `HOLD`: wait for the 16th lane write, then assert `pack_dvld_o`.
  - On `pack_ack_i`, drop `pack_dvld_o` and clear the lanes.
  - If the sample count equals `N_SAMPLES`, pulse `done_o` and go to `IDLE`; otherwise go to `REQ`.
- Lane packing: sample k of a group occupies `pack_dout_o[8k+7:8k]`, with sample 0 in the LSBs.
- Weight arithmetic: 0..128 fits in 8 bits unsigned; the all-ones word gives 8'h80. No saturation is needed.
- Only one FIFO request is outstanding at any time.
- Boundary rules:
  - `start_i` while `busy_o` is high is ignored.
  - `fifo_dvld_i` outside `WAIT` is ignored.
  - `pack_ack_i` while `pack_dvld_o` is low is ignored.
  - Reset mid-run returns to `IDLE` immediately and discards all data.
- `busy_o` is high in every state except `IDLE`.

## Timing
- Reset values: all outputs 0; state `IDLE`; all counters 0.
- `fifo_drdy_o` rises the cycle after `start_i` is sampled.
- Request spacing: the next request issues the cycle after `fifo_dvld_i`. Minimum period is 2 cycles per sample when the FIFO answers in the next cycle.
- Popcount latency: 2 cycles from the `fifo_dvld_i` edge to the lane write.
- `pack_dvld_o` rises the cycle after the 16th lane write.
- After `pack_ack_i` is sampled, `fifo_drdy_o` pulses on the next cycle.
- The final `done_o` pulse is coincident with the cycle `pack_dvld_o` falls.
- Timeout: `err_o` rises exactly `TIMEOUT` cycles after the `fifo_drdy_o` cycle when no `fifo_dvld_i` arrives.

## Configuration
- `SENS_POPCOUNT_EN` defined: behaviour exactly as described above.
- `SENS_POPCOUNT_EN` undefined:
  - Compression and lane packing are removed.
  - Each FIFO word is registered directly to `pack_dout_o`, and `pack_dvld_o` rises 1 cycle after `fifo_dvld_i`.
  - `HOLD` is entered after every sample, so one ack is required per sample.
  - `N_SAMPLES` has no multiple-of-16 constraint.

## Structure
- Package `sens_pack_pkg` holds:
  - the state enum;
  - `LANE_W = 8`, `LANES = 16`;
  - the timeout counter width, derived as `$clog2(TIMEOUT+1)`.
- Sub-module `popcount128`, compiled only under `SENS_POPCOUNT_EN`:
  - stage 1: sixteen 8-bit group counts, each 4 bits, registered;
  - stage 2: adder tree to 8 bits, registered;
  - it has an internal valid bit that travels with the data.

## Test plan
- Words 0..15 all-ones, with the FIFO answering in 1 cycle and ack given immediately -> `pack_dout_o` = 128'h8080…80, one `pack_dvld_o`.
- `N_SAMPLES` = 32, word k = (1<<k)-1 -> two outputs. Lane k carries k mod 128. `done_o` is a single pulse, coincident with the second ack.
- FIFO never asserts `fifo_dvld_i` -> `err_o` = 1 at exactly cycle 255 after the request; `busy_o` = 0; no `done_o`.
- `pack_ack_i` withheld for 50 cycles -> no `fifo_drdy_o` during the hold; `pack_dout_o` stable throughout.
- Reset asserted mid-run at sample 7, then `start_i` -> a fresh run with lane 0 holding the first new sample. `start_i` pulses during `busy_o` are ignored.
- `SENS_POPCOUNT_EN` undefined, words A,B -> outputs A then B, each exactly 1 cycle after its `fifo_dvld_i`.
